// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package cpu_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    RESP,
    HOLD,
    HALT
  } fetch_state_t;

  // Value the PC stage presents out of reset; the fetch stage never forces it.
  localparam logic [31:0] RESET_VECTOR    = 32'hBFC0_0000;
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

  // True when the address does not point at a 32-bit word boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/cpu_fetch.sv
// Instruction-fetch stage: one Avalon word read per instruction, holds the
// fetched word until the consumer takes it, and strobes the PC once per fetch.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR  = 32'h0000_0000,
  parameter logic [3:0]  BYTEEN_ALL = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic        pc_wen_o,
  output logic [31:0] mem_address_o,
  output logic        mem_read_o,
  output logic [3:0]  mem_byteenable_o,
  input  logic        mem_waitrequest_i,
  input  logic [31:0] mem_readdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        halted_o,
  output logic        fault_o
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  addr_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  instr_addr_reg;
  logic         halted_reg;
  logic         fault_reg;

  // Next-state selection; HALT is terminal, only reset leaves it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  state_next = CHECK;
      CHECK: begin
        if (pc_i == HALT_ADDR || is_misaligned(pc_i)) begin
          state_next = HALT;
        end else begin
          state_next = REQ;
        end
      end
      REQ:   if (!mem_waitrequest_i) state_next = RESP;
      RESP:  state_next = HOLD;
      HOLD:  if (instr_ready_i) state_next = CHECK;
      HALT:  state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // State, latched fetch address, captured instruction and sticky stop flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= 32'h0;
      instr_reg      <= 32'h0;
      instr_addr_reg <= 32'h0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        CHECK: begin
          // Halt takes priority so the two flags can never both be set.
          if (pc_i == HALT_ADDR) begin
            halted_reg <= 1'b1;
          end else if (is_misaligned(pc_i)) begin
            fault_reg <= 1'b1;
          end else begin
            addr_reg <= pc_i;
          end
        end
        RESP: begin
          // Read data is only meaningful the cycle after an accepted read.
          instr_reg      <= mem_readdata_i;
          instr_addr_reg <= addr_reg;
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state; nothing here depends on inputs.
  always_comb begin
    mem_read_o       = (state_reg == REQ);
    mem_address_o    = addr_reg;
    mem_byteenable_o = (state_reg == REQ) ? BYTEEN_ALL : 4'b0000;
    pc_wen_o         = (state_reg == RESP);
    instr_valid_o    = (state_reg == HOLD);
    instr_o          = instr_reg;
    instr_addr_o     = instr_addr_reg;
    halted_o         = halted_reg;
    fault_o          = fault_reg;
  end

endmodule
